// File: rtl/udp_pkg.sv
// Shared types and field widths for the UDP TX arbitration path.
package udp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } arb_state_e;

    localparam int UDP_PORT_W = 16;
    localparam int IP_ADDR_W  = 32;
    localparam int IP_PROTO_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!o_any && i_req[cand]) begin
                o_any       = 1'b1;
                o_gnt[cand] = 1'b1;
                o_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin sharing of the UDP TX header + payload path among NUM_PORTS requesters.
// state   | meaning
// IDLE    | no grant; winner picked and header latched on the next request
// HDR     | latched header offered to UDP TX, waiting for m_hdr_trdy
// PAYLOAD | granted payload stream passed through until its tlast handshake
module udp_tx_arbiter
    import udp_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int AXI_DATA_WIDTH = 8
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic [NUM_PORTS-1:0]                s_hdr_tvalid,
    output logic [NUM_PORTS-1:0]                s_hdr_trdy,
    input  logic [UDP_PORT_W*NUM_PORTS-1:0]     s_udp_src_port,
    input  logic [UDP_PORT_W*NUM_PORTS-1:0]     s_udp_dst_port,
    input  logic [IP_ADDR_W*NUM_PORTS-1:0]      s_ip_src_ip_addr,
    input  logic [IP_ADDR_W*NUM_PORTS-1:0]      s_ip_dst_ip_addr,
    input  logic [IP_PROTO_W*NUM_PORTS-1:0]     s_ip_protocol,
    input  logic [AXI_DATA_WIDTH*NUM_PORTS-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                s_axis_tlast,
    output logic [NUM_PORTS-1:0]                s_axis_trdy,
    output logic                                m_hdr_tvalid,
    input  logic                                m_hdr_trdy,
    output logic [UDP_PORT_W-1:0]               m_udp_src_port,
    output logic [UDP_PORT_W-1:0]               m_udp_dst_port,
    output logic [IP_ADDR_W-1:0]                m_ip_src_ip_addr,
    output logic [IP_ADDR_W-1:0]                m_ip_dst_ip_addr,
    output logic [IP_PROTO_W-1:0]               m_ip_protocol,
    output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_trdy,
    output logic [NUM_PORTS-1:0]                o_grant,
    output logic                                o_busy
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic                   hdr_vld_q, hdr_vld_d;
    logic                   busy_q, busy_d;
    logic [UDP_PORT_W-1:0]  src_port_q, src_port_d;
    logic [UDP_PORT_W-1:0]  dst_port_q, dst_port_d;
    logic [IP_ADDR_W-1:0]   src_ip_q, src_ip_d;
    logic [IP_ADDR_W-1:0]   dst_ip_q, dst_ip_d;
    logic [IP_PROTO_W-1:0]  proto_q, proto_d;

    logic [NUM_PORTS-1:0]   rr_gnt;
    logic [IDX_W-1:0]       rr_idx;
    logic                   rr_any;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req (s_hdr_tvalid),
        .i_ptr (ptr_q),
        .o_gnt (rr_gnt),
        .o_idx (rr_idx),
        .o_any (rr_any)
    );

    // All requester-facing handshakes are gated by state so nothing leaks outside a grant.
    always_comb begin
        s_hdr_trdy    = '0;
        s_axis_trdy   = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        if (state_q == ST_HDR) begin
            s_hdr_trdy = grant_q & {NUM_PORTS{m_hdr_trdy}};
        end
        if (state_q == ST_PAYLOAD) begin
            s_axis_trdy   = grant_q & {NUM_PORTS{m_axis_trdy}};
            m_axis_tvalid = s_axis_tvalid[gidx_q];
            m_axis_tlast  = s_axis_tlast[gidx_q];
            m_axis_tdata  = s_axis_tdata[gidx_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        grant_d    = grant_q;
        hdr_vld_d  = hdr_vld_q;
        src_port_d = src_port_q;
        dst_port_d = dst_port_q;
        src_ip_d   = src_ip_q;
        dst_ip_d   = dst_ip_q;
        proto_d    = proto_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    state_d    = ST_HDR;
                    grant_d    = rr_gnt;
                    gidx_d     = rr_idx;
                    hdr_vld_d  = 1'b1;
                    src_port_d = s_udp_src_port[rr_idx*UDP_PORT_W +: UDP_PORT_W];
                    dst_port_d = s_udp_dst_port[rr_idx*UDP_PORT_W +: UDP_PORT_W];
                    src_ip_d   = s_ip_src_ip_addr[rr_idx*IP_ADDR_W +: IP_ADDR_W];
                    dst_ip_d   = s_ip_dst_ip_addr[rr_idx*IP_ADDR_W +: IP_ADDR_W];
                    proto_d    = s_ip_protocol[rr_idx*IP_PROTO_W +: IP_PROTO_W];
                end
            end
            ST_HDR: begin
                if (hdr_vld_q && m_hdr_trdy) begin
                    hdr_vld_d = 1'b0;
                    state_d   = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (m_axis_tvalid && m_axis_trdy && m_axis_tlast) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == IDX_W'(NUM_PORTS-1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                grant_d   = '0;
                hdr_vld_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            grant_q    <= '0;
            hdr_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            src_port_q <= '0;
            dst_port_q <= '0;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
            proto_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            hdr_vld_q  <= hdr_vld_d;
            busy_q     <= busy_d;
            src_port_q <= src_port_d;
            dst_port_q <= dst_port_d;
            src_ip_q   <= src_ip_d;
            dst_ip_q   <= dst_ip_d;
            proto_q    <= proto_d;
        end
    end

    assign o_grant          = grant_q;
    assign o_busy           = busy_q;
    assign m_hdr_tvalid     = hdr_vld_q;
    assign m_udp_src_port   = src_port_q;
    assign m_udp_dst_port   = dst_port_q;
    assign m_ip_src_ip_addr = src_ip_q;
    assign m_ip_dst_ip_addr = dst_ip_q;
    assign m_ip_protocol    = proto_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: directed packets, monitor checks header, grant order and payload.
module tb_udp_tx_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] d;
        logic [31:0] si;
        logic [31:0] di;
        logic [7:0]  pr;
    } hdr_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } pay_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]      s_hdr_tvalid, s_hdr_trdy;
    logic [16*NP-1:0]   s_udp_src_port, s_udp_dst_port;
    logic [32*NP-1:0]   s_ip_src_ip_addr, s_ip_dst_ip_addr;
    logic [8*NP-1:0]    s_ip_protocol;
    logic [DW*NP-1:0]   s_axis_tdata;
    logic [NP-1:0]      s_axis_tvalid, s_axis_tlast, s_axis_trdy;
    logic               m_hdr_tvalid, m_hdr_trdy;
    logic [15:0]        m_udp_src_port, m_udp_dst_port;
    logic [31:0]        m_ip_src_ip_addr, m_ip_dst_ip_addr;
    logic [7:0]         m_ip_protocol;
    logic [DW-1:0]      m_axis_tdata;
    logic               m_axis_tvalid, m_axis_tlast, m_axis_trdy;
    logic [NP-1:0]      o_grant;
    logic               o_busy;

    logic        hv[NP], tv[NP], tl[NP];
    logic [15:0] sp[NP], dp[NP];
    logic [31:0] sip[NP], dip[NP];
    logic [7:0]  pr[NP], td[NP];

    logic hdr_rdy = 1'b1;
    logic axis_rdy_base = 1'b1;
    logic toggle_en = 1'b0;
    logic tog = 1'b0;

    assign m_hdr_trdy  = hdr_rdy;
    assign m_axis_trdy = toggle_en ? tog : axis_rdy_base;
    always @(posedge clk) begin
        #1;
        tog = ~tog;
    end

    for (genvar k = 0; k < NP; k++) begin : g_pack
        assign s_hdr_tvalid[k]             = hv[k];
        assign s_udp_src_port[16*k +: 16]  = sp[k];
        assign s_udp_dst_port[16*k +: 16]  = dp[k];
        assign s_ip_src_ip_addr[32*k +: 32] = sip[k];
        assign s_ip_dst_ip_addr[32*k +: 32] = dip[k];
        assign s_ip_protocol[8*k +: 8]     = pr[k];
        assign s_axis_tdata[DW*k +: DW]    = td[k];
        assign s_axis_tvalid[k]            = tv[k];
        assign s_axis_tlast[k]             = tl[k];
    end

    udp_tx_arbiter #(.NUM_PORTS(NP), .AXI_DATA_WIDTH(DW)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .s_hdr_tvalid     (s_hdr_tvalid),
        .s_hdr_trdy       (s_hdr_trdy),
        .s_udp_src_port   (s_udp_src_port),
        .s_udp_dst_port   (s_udp_dst_port),
        .s_ip_src_ip_addr (s_ip_src_ip_addr),
        .s_ip_dst_ip_addr (s_ip_dst_ip_addr),
        .s_ip_protocol    (s_ip_protocol),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_trdy      (s_axis_trdy),
        .m_hdr_tvalid     (m_hdr_tvalid),
        .m_hdr_trdy       (m_hdr_trdy),
        .m_udp_src_port   (m_udp_src_port),
        .m_udp_dst_port   (m_udp_dst_port),
        .m_ip_src_ip_addr (m_ip_src_ip_addr),
        .m_ip_dst_ip_addr (m_ip_dst_ip_addr),
        .m_ip_protocol    (m_ip_protocol),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_trdy      (m_axis_trdy),
        .o_grant          (o_grant),
        .o_busy           (o_busy)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_grant[$];
    hdr_t exp_hdr[NP][$];
    pay_t exp_pay[NP][$];

    task automatic check_eq(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm, input int info);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not reached (info %0d) at %0t", nm, info, $time);
    endtask

    function automatic int oh2i(input logic [NP-1:0] v);
        int r = -1;
        int c = 0;
        for (int k = 0; k < NP; k++) begin
            if (v[k]) begin
                r = k;
                c++;
            end
        end
        return (c == 1) ? r : -1;
    endfunction

    function automatic bit queues_empty();
        bit e = (exp_grant.size() == 0);
        for (int k = 0; k < NP; k++) begin
            if (exp_hdr[k].size() != 0 || exp_pay[k].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    // Requester model: header and first byte presented together; byte i carries b0+i.
    task automatic send_pkt(input int p, input logic [15:0] s, input logic [15:0] d,
                            input logic [31:0] si, input logic [31:0] di,
                            input logic [7:0] prv, input int len, input logic [7:0] b0);
        int   i;
        int   budget;
        hdr_t h;
        pay_t y;
        h.s = s; h.d = d; h.si = si; h.di = di; h.pr = prv;
        exp_hdr[p].push_back(h);
        for (int k = 0; k < len; k++) begin
            y.data = b0 + 8'(k);
            y.last = (k == len - 1);
            exp_pay[p].push_back(y);
        end
        sp[p] = s; dp[p] = d; sip[p] = si; dip[p] = di; pr[p] = prv;
        td[p] = b0; tl[p] = (len == 1); tv[p] = 1'b1; hv[p] = 1'b1;
        budget = 0;
        while (hv[p]) begin
            @(negedge clk);
            if (!rst_n) begin
                hv[p] = 1'b0; tv[p] = 1'b0; tl[p] = 1'b0;
                return;
            end
            if (s_hdr_trdy[p]) begin
                @(posedge clk);
                #1 hv[p] = 1'b0;
            end else if (++budget > 300) begin
                fail_now("hdr_handshake_timeout", p);
                hv[p] = 1'b0; tv[p] = 1'b0; tl[p] = 1'b0;
                return;
            end
        end
        i = 0;
        budget = 0;
        while (i < len) begin
            @(negedge clk);
            if (!rst_n) begin
                tv[p] = 1'b0; tl[p] = 1'b0;
                return;
            end
            if (s_axis_trdy[p]) begin
                @(posedge clk);
                #1 i++;
                if (i < len) begin
                    td[p] = b0 + 8'(i);
                    tl[p] = (i == len - 1);
                end else begin
                    tv[p] = 1'b0;
                    tl[p] = 1'b0;
                end
            end else if (++budget > 300) begin
                fail_now("payload_timeout", p);
                tv[p] = 1'b0; tl[p] = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_done(input string nm);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (queues_empty() && !o_busy && s_hdr_tvalid == '0 && s_axis_tvalid == '0) return;
        end
        fail_now(nm, exp_grant.size());
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: pops the expected stream whenever the DUT completes a handshake.
    logic stall_prev = 1'b0;
    hdr_t prev_hdr;
    bit   gap_en = 1'b0;
    bit   gap_seen_busy = 1'b0;
    int   gap = 0;

    always @(negedge clk) begin : mon
        int   g;
        int   eg;
        hdr_t cur;
        pay_t got;
        cur = {m_udp_src_port, m_udp_dst_port, m_ip_src_ip_addr, m_ip_dst_ip_addr, m_ip_protocol};
        got = {m_axis_tlast, m_axis_tdata};
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            g = oh2i(o_grant);
            if (o_busy) check_eq("nongrant_trdy", {s_hdr_trdy & ~o_grant, s_axis_trdy & ~o_grant}, 0);
            if (m_hdr_tvalid && m_hdr_trdy) begin
                if (g < 0 || exp_grant.size() == 0) begin
                    fail_now("unexpected_hdr", int'(o_grant));
                end else begin
                    eg = exp_grant.pop_front();
                    check_eq("grant_order", g, eg);
                    if (exp_hdr[g].size() == 0) fail_now("unexpected_hdr_port", g);
                    else check_eq("hdr_fields", cur, exp_hdr[g].pop_front());
                end
            end
            if (m_axis_tvalid && m_axis_trdy) begin
                if (g < 0 || exp_pay[g].size() == 0) fail_now("unexpected_byte", int'(o_grant));
                else check_eq("payload", got, exp_pay[g].pop_front());
            end
            if (m_hdr_tvalid && stall_prev) check_eq("hdr_stable", cur, prev_hdr);
            stall_prev = m_hdr_tvalid && !m_hdr_trdy;
            prev_hdr   = cur;
            if (gap_en) begin
                if (!o_busy) begin
                    gap++;
                end else begin
                    if (gap_seen_busy && gap > 0) check_eq("idle_gap", gap, 1);
                    gap_seen_busy = 1'b1;
                    gap = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int k = 0; k < NP; k++) begin
            hv[k] = 1'b0; tv[k] = 1'b0; tl[k] = 1'b0;
            sp[k] = '0; dp[k] = '0; sip[k] = '0; dip[k] = '0; pr[k] = '0; td[k] = '0;
        end

        #2;
        check_eq("rst_grant", o_grant, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_hdr_valid", m_hdr_tvalid, 0);
        check_eq("rst_hdr_regs", {m_udp_src_port, m_udp_dst_port, m_ip_src_ip_addr, m_ip_dst_ip_addr, m_ip_protocol}, 0);
        check_eq("rst_axis", {m_axis_tvalid, m_axis_tlast, s_axis_trdy, s_hdr_trdy}, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single requester on port 2, grant one cycle after valid
        @(posedge clk);
        #1;
        exp_grant.push_back(2);
        fork
            send_pkt(2, 16'h1234, 16'h0050, 32'hC0A80001, 32'hC0A80002, 8'h11, 5, 8'hA0);
        join_none
        @(negedge clk);
        check_eq("t1_grant_before", o_grant, 0);
        @(negedge clk);
        check_eq("t1_grant_latency", {o_grant, m_hdr_tvalid, o_busy}, {4'b0100, 1'b1, 1'b1});
        wait_done("t1_done");

        // Pointer now 3: port 3 must beat port 1
        @(posedge clk);
        #1;
        exp_grant.push_back(3);
        exp_grant.push_back(1);
        fork
            send_pkt(1, 16'h1111, 16'h2222, 32'h0A000001, 32'h0A000002, 8'h06, 2, 8'hB0);
            send_pkt(3, 16'h3333, 16'h4444, 32'h0A000003, 32'h0A000004, 8'h11, 3, 8'hC0);
        join_none
        wait_done("t2_done");

        // All four requesting from pointer 0, one idle cycle between packets
        reset_pulse();
        gap = 0;
        gap_seen_busy = 1'b0;
        gap_en = 1'b1;
        for (int k = 0; k < NP; k++) exp_grant.push_back(k);
        for (int k = 0; k < NP; k++) begin
            automatic int kk = k;
            fork
                send_pkt(kk, 16'(16'h2000 + kk), 16'(16'h3000 + kk), 32'(32'hAC100000 + kk),
                         32'(32'hAC10FF00 + kk), 8'h11, 3, 8'(16 * kk + 1));
            join_none
        end
        wait_done("t3_done");
        gap_en = 1'b0;

        // Header stall then toggling payload ready; port 2 waits un-granted
        @(posedge clk);
        #1;
        hdr_rdy = 1'b0;
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        fork
            send_pkt(1, 16'hAAAA, 16'hBBBB, 32'h01020304, 32'h05060708, 8'h11, 4, 8'hD0);
            send_pkt(2, 16'hCCCC, 16'hDDDD, 32'h11223344, 32'h55667788, 8'h06, 2, 8'hE0);
        join_none
        repeat (5) @(negedge clk);
        check_eq("t4_stalled_hdr", {o_grant, m_hdr_tvalid, s_hdr_trdy}, {4'b0010, 1'b1, 4'b0000});
        @(posedge clk);
        #1;
        hdr_rdy = 1'b1;
        toggle_en = 1'b1;
        wait_done("t4_done");
        toggle_en = 1'b0;

        // Async reset while byte 2 of a 6-byte packet is on the bus
        @(posedge clk);
        #1;
        exp_grant.push_back(0);
        fork
            send_pkt(0, 16'h0F0F, 16'hF0F0, 32'hDEADBEEF, 32'hCAFEF00D, 8'h11, 6, 8'h60);
        join_none
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_trdy && m_axis_tdata == 8'h61) found = 1'b1;
        end
        if (!found) fail_now("t5_byte2_timeout", 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_grant_busy", {o_grant, o_busy, m_hdr_tvalid}, 0);
        check_eq("t5_async_axis", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_trdy, s_hdr_trdy}, 0);
        check_eq("t5_async_hdr_regs", {m_udp_src_port, m_udp_dst_port, m_ip_src_ip_addr, m_ip_dst_ip_addr, m_ip_protocol}, 0);
        repeat (2) @(negedge clk);
        exp_grant.delete();
        for (int k = 0; k < NP; k++) begin
            exp_hdr[k].delete();
            exp_pay[k].delete();
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_grant.push_back(0);
        fork
            send_pkt(0, 16'h5555, 16'h6666, 32'h0A0A0A0A, 32'h0B0B0B0B, 8'h11, 2, 8'h70);
        join_none
        @(negedge clk);
        check_eq("t5_regrant_before", o_grant, 0);
        @(negedge clk);
        check_eq("t5_regrant", {o_grant, m_hdr_tvalid}, {4'b0001, 1'b1});
        wait_done("t5_done");

        // Port 1 requests while port 0 is mid-payload
        @(posedge clk);
        #1;
        exp_grant.push_back(0);
        fork
            send_pkt(0, 16'h7777, 16'h8888, 32'h0C0C0C0C, 32'h0D0D0D0D, 8'h11, 4, 8'h80);
        join_none
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (m_axis_tvalid && o_grant == 4'b0001) found = 1'b1;
        end
        if (!found) fail_now("t6_payload_timeout", 0);
        @(posedge clk);
        #1;
        exp_grant.push_back(1);
        fork
            send_pkt(1, 16'h9999, 16'hAAAB, 32'h0E0E0E0E, 32'h0F0F0F0F, 8'h06, 2, 8'h90);
        join_none
        @(negedge clk);
        check_eq("t6_no_early_trdy", {s_axis_trdy[1], o_grant}, {1'b0, 4'b0001});
        wait_done("t6_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
